// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline control slice.
//   state_e   : hazard-controller FSM encoding (RUN=0, MEM_WAIT=1, BR_FLUSH=2)
//   REG_W_DEF : default register-index width
//   X0        : index of the hard-wired zero register
//   NOP_INSN  : instruction word the IF/ID register loads when flushed (addi x0,x0,0)
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2
  } state_e;

  localparam int unsigned REG_W_DEF = 5;
  localparam int unsigned X0        = 0;
  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when the instruction in IF/ID reads the destination of a load that is
// currently in ID/EX. x0 never creates a hazard.
// Ports:
//   rs1, rs2  : source indices of the instruction in IF/ID
//   uses_rs2  : IF/ID instruction actually reads rs2
//   rd        : destination index in ID/EX
//   memread   : ID/EX instruction is a load
//   hz        : load-use hazard present
module load_use_detect
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             uses_rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             memread,
  output logic             hz
);

  always_comb begin
    hz = memread && (rd != REG_W'(X0)) &&
         ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RISC-V pipeline.
// Drives write-enable, flush and bubble controls of the PC, IF/ID, ID/EX and
// EX/MEM registers, resolving load-use hazards, taken branches (resolved in
// MEM) and multi-cycle data-memory waits.
// Ports:
//   clk, reset        : clock (rising edge), synchronous active-high reset
//   ifid_rs1/rs2      : sources of IF/ID instruction; ifid_uses_rs2 qualifies rs2
//   idex_rd, idex_memread : destination / load flag of ID/EX instruction
//   branch_taken      : taken branch resolved in EX/MEM
//   exmem_memaccess   : EX/MEM holds a load/store; dmem_ready completes it
//   pc_write, ifid_write, idex_write, exmem_write : register load enables
//   ifid_flush, idex_bubble, exmem_flush          : NOP / zero-control loads
//   stall_cycles, flush_events : saturating statistics counters
// Build option: define HAZARD_STATS_EN to implement the statistics counters;
// otherwise both counter outputs are tied to zero and no counter flops exist.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned REG_W      = REG_W_DEF,
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_memread,
  input  logic             branch_taken,
  input  logic             exmem_memaccess,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  state_e     state_q, state_d;
  logic [1:0] pen_cnt_q, pen_cnt_d;
  logic       hz;
  logic       busy;
  logic       mem_hold;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_lud (
    .rs1      (ifid_rs1),
    .rs2      (ifid_rs2),
    .uses_rs2 (ifid_uses_rs2),
    .rd       (idex_rd),
    .memread  (idex_memread),
    .hz       (hz)
  );

  always_comb begin
    busy = exmem_memaccess && !dmem_ready;
    // Once waiting, only dmem_ready releases the freeze; in RUN it takes an access.
    mem_hold = (state_q == MEM_WAIT) ? !dmem_ready : busy;

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    exmem_write = 1'b1;
    exmem_flush = 1'b0;
    state_d     = state_q;
    pen_cnt_d   = pen_cnt_q;

    case (state_q)
      BR_FLUSH: begin
        if (busy) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
        end else begin
          pc_write   = 1'b0;
          ifid_flush = 1'b1;
          if (pen_cnt_q == 2'd0) state_d = RUN;
          else                   pen_cnt_d = pen_cnt_q - 2'd1;
        end
      end
      default: begin
        // RUN and the releasing cycle of MEM_WAIT share the same rules.
        if (mem_hold) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          state_d     = MEM_WAIT;
        end else if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_flush = 1'b1;
          if (BR_PENALTY > 0) begin
            state_d   = BR_FLUSH;
            pen_cnt_d = 2'(BR_PENALTY - 1);
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
          if (hz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
      end
    endcase

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      state_d     = RUN;
      pen_cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    pen_cnt_q <= pen_cnt_d;
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (reset) begin
      stall_cycles_d = '0;
      flush_events_d = '0;
    end else begin
      if (!pc_write && (state_q != BR_FLUSH) && (stall_cycles_q != '1))
        stall_cycles_d = stall_cycles_q + 1'b1;
      // Outside reset, exmem_flush is asserted only by a taken branch.
      if (exmem_flush && (flush_events_q != '1))
        flush_events_d = flush_events_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    stall_cycles_q <= stall_cycles_d;
    flush_events_q <= flush_events_d;
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives write-enable, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three hazards: load-use hazards, taken branches (resolved in MEM) and multi-cycle data-memory waits.
- Sits beside the pipeline registers. Combinational hazard detection feeds a small FSM that owns the multi-cycle cases.

Parameters:
REG_W, 5, register-index width
BR_PENALTY, 1, extra fetch-bubble cycles after the branch flush cycle (0..3)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
ifid_rs1  in  REG_W  rs1 of instruction in IF/ID
ifid_rs2  in  REG_W  rs2 of instruction in IF/ID
ifid_uses_rs2  in  1  instruction in IF/ID reads rs2
idex_rd  in  REG_W  rd in ID/EX
idex_memread  in  1  ID/EX Memread
branch_taken  in  1  taken branch resolved in EX/MEM
exmem_memaccess  in  1  EX/MEM holds a load/store
dmem_ready  in  1  data memory completes this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP
idex_write  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX control fields load 0
exmem_write  out  1  EX/MEM load enable
exmem_flush  out  1  EX/MEM control fields load 0
stall_cycles  out  CNT_W  saturating stall-cycle count
flush_events  out  CNT_W  saturating taken-branch count

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Definitions:
  - hz = idex_memread && idex_rd!=0 && (idex_rd==ifid_rs1 || (ifid_uses_rs2 && idex_rd==ifid_rs2)).
  - busy = exmem_memaccess && !dmem_ready.
- Default outputs: all write enables 1; all flush/bubble outputs 0.
- FSM states: RUN, MEM_WAIT, BR_FLUSH. Outputs are combinational from state plus inputs; the next state is registered.
- RUN, evaluated in priority order:
  1. busy: pc_write, ifid_write, idex_write and exmem_write = 0 (freeze). Next state MEM_WAIT.
  2. branch_taken: ifid_flush, idex_bubble and exmem_flush = 1; pc_write = 1 (loads target). flush_events increments. Next state is BR_FLUSH with pen_cnt = BR_PENALTY-1 if BR_PENALTY>0, else RUN.
  3. hz: pc_write = 0, ifid_write = 0, idex_bubble = 1. Stays in RUN. The stall lasts exactly 1 cycle because the load advances to EX/MEM.
- MEM_WAIT:
  - While dmem_ready = 0: full freeze, as in RUN case 1.
  - In the cycle dmem_ready = 1: outputs and next state follow the RUN rules with busy forced 0.
- BR_FLUSH:
  - pc_write = 0 and ifid_flush = 1; the downstream registers advance.
  - pen_cnt decrements each cycle. Return to RUN on the cycle pen_cnt==0.
  - branch_taken is ignored in this state.
  - If busy: full freeze, pen_cnt holds, state holds.
- stall_cycles increments in every cycle where pc_write = 0 and the state is not BR_FLUSH. Both counters saturate at all-ones.
- Reset (including mid-MEM_WAIT or mid-BR_FLUSH):
  - Next state RUN; pen_cnt = 0; both counters = 0.
  - While reset is high: all write enables = 0, and ifid_flush, idex_bubble and exmem_flush = 1.
- Register x0 never creates a hazard.

Optional Feature:
HAZARD_STATS_EN
- Defined: stall_cycles and flush_events are implemented as above.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated. All other behaviour is unchanged.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - the FSM state encoding (RUN=0, MEM_WAIT=1, BR_FLUSH=2);
  - the REG_W default;
  - the X0 constant;
  - the NOP instruction constant used by the IF/ID flush.
- Sub-module load_use_detect (combinational, computes hz) is natural and reusable by the forwarding unit.
- The FSM and counters stay in the top module.

Test Plan:
1. idex_memread=1, idex_rd=5, ifid_rs1=5 in RUN -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; next cycle all defaults; stall_cycles=1.
2. idex_rd=0, idex_memread=1, ifid_rs1=0 -> no stall. Separately, ifid_rs2=7 matches idex_rd=7 with ifid_uses_rs2=0 -> no stall.
3. branch_taken=1 with BR_PENALTY=1 -> flush cycle asserts ifid_flush, idex_bubble and exmem_flush; the next cycle is BR_FLUSH with pc_write=0 and ifid_flush=1; then RUN; flush_events=1.
4. exmem_memaccess=1 with dmem_ready low for 3 cycles, plus hz true simultaneously -> 3 full-freeze cycles; on the dmem_ready=1 cycle the load-use stall applies; stall_cycles=4.
5. Assert reset during the second cycle of MEM_WAIT -> the reset cycle shows flushes=1 and enables=0; the cycle after shows the RUN defaults; counters=0.
6. Stats overflow with CNT_W=4 and HAZARD_STATS_EN defined: 20 load-use stalls -> stall_cycles=15. With the macro undefined -> stall_cycles=0.
